// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_e  - sequencer FSM encoding (also exported on state_o for debug)
//   cause_e  - winning hazard cause for the current cycle, highest priority first
//   R_*      - bit index of each pipeline register in the en/clear vectors
package hazard_pkg;

  localparam int RF_AW_DEF = 5;
  localparam int CNT_W_DEF = 32;
  localparam int NUM_PREG  = 4;

  localparam int R_IF_ID  = 0;
  localparam int R_ID_EX  = 1;
  localparam int R_EX_MEM = 2;
  localparam int R_MEM_WB = 3;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MC_WAIT   = 2'd1,
    ST_TRAP_PEND = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_MEM   = 3'd1,
    C_TRAP  = 3'd2,
    C_REDIR = 3'd3,
    C_MC    = 3'd4,
    C_LU    = 3'd5,
    C_FETCH = 3'd6
  } cause_e;

endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: two free-running event counters, wrap modulo 2^W.
//   clk, rst_n      clock, synchronous active-low reset (counters -> 0)
//   stall_inc       count one stall cycle
//   flush_inc       count one flush event
//   stall_cnt/flush_cnt  current counts
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_inc,
  input  logic         flush_inc,
  output logic [W-1:0] stall_cnt,
  output logic [W-1:0] flush_cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + W'(1);
      if (flush_inc) flush_cnt <= flush_cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage core.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds perf_stall_o / perf_flush_o).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_ready_i                      fetch delivered an instruction
//   id_rs1_i/id_use_rs1_i, id_rs2_i/id_use_rs2_i   ID source operands
//   ex_valid_i, ex_is_load_i, ex_rd_i              EX instruction info
//   ex_mc_start_i, ex_mc_done_i     multicycle EX op handshake
//   mem_req_i, mem_ready_i          D-mem access / ack
//   ex_redirect_i, trap_i           mispredict from EX, exception from MEM
//   pc_en_o, *_en_o, *_clear_o      PC and pipeline register controls
//   trap_take_o                     trap vector select pulse
//   state_o                         FSM state (debug)
//   perf_stall_o, perf_flush_o      perf counters (macro only)
// All control outputs are combinational from state and inputs.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RF_AW = RF_AW_DEF
`ifdef HAZARD_PERF_CNT_EN
  ,parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_ready_i,
  input  logic [RF_AW-1:0] id_rs1_i,
  input  logic             id_use_rs1_i,
  input  logic [RF_AW-1:0] id_rs2_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_load_i,
  input  logic [RF_AW-1:0] ex_rd_i,
  input  logic             ex_mc_start_i,
  input  logic             ex_mc_done_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             ex_redirect_i,
  input  logic             trap_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_clear_o,
  output logic             id_ex_en_o,
  output logic             id_ex_clear_o,
  output logic             ex_mem_en_o,
  output logic             ex_mem_clear_o,
  output logic             mem_wb_en_o,
  output logic             mem_wb_clear_o,
  output logic             trap_take_o,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [CNT_W-1:0] perf_stall_o,
  output logic [CNT_W-1:0]  perf_flush_o
`endif
);

  state_e              state, state_n;
  cause_e              cause;
  logic                mem_stall, mc_stall, load_use, trap_act;
  logic [NUM_PREG-1:0] reg_en, reg_clr;

  assign mem_stall = mem_req_i & ~mem_ready_i;
  // A single-cycle op (start & done together) never stalls.
  assign mc_stall  = (ex_mc_start_i | (state == ST_MC_WAIT)) & ~ex_mc_done_i;
  assign load_use  = ex_valid_i & ex_is_load_i & (ex_rd_i != '0) &
                     ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                      (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
  // A trap seen during a D-mem wait is parked in TRAP_PEND until the wait ends.
  assign trap_act  = trap_i | (state == ST_TRAP_PEND);

  always_comb begin
    cause = C_NONE;
    if      (mem_stall)     cause = C_MEM;
    else if (trap_act)      cause = C_TRAP;
    else if (ex_redirect_i) cause = C_REDIR;
    else if (mc_stall)      cause = C_MC;
    else if (load_use)      cause = C_LU;
    else if (!if_ready_i)   cause = C_FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (trap_i && mem_stall)  state_n = ST_TRAP_PEND;
    else if (cause == C_TRAP) state_n = ST_RUN;  // flush squashes any multicycle op
    else begin
      unique case (state)
        ST_RUN:       if (ex_mc_start_i && !ex_mc_done_i) state_n = ST_MC_WAIT;
        ST_MC_WAIT:   if (ex_mc_done_i) state_n = ST_RUN;
        ST_TRAP_PEND: state_n = ST_TRAP_PEND;
        default:      state_n = ST_RUN;
      endcase
    end
  end

  always_comb begin
    reg_en      = '1;
    reg_clr     = '0;
    pc_en_o     = 1'b1;
    trap_take_o = 1'b0;
    if (!rst_n) begin
      reg_en  = '0;
      reg_clr = '1;
      pc_en_o = 1'b0;
    end else begin
      unique case (cause)
        C_MEM: begin
          reg_en            = '0;
          pc_en_o           = 1'b0;
          reg_clr[R_MEM_WB] = 1'b1;
        end
        C_TRAP: begin
          reg_clr     = '1;
          trap_take_o = 1'b1;
        end
        C_REDIR: begin
          reg_clr[R_IF_ID] = 1'b1;
          reg_clr[R_ID_EX] = 1'b1;
        end
        C_MC: begin
          pc_en_o           = 1'b0;
          reg_en[R_IF_ID]   = 1'b0;
          reg_en[R_ID_EX]   = 1'b0;
          reg_en[R_EX_MEM]  = 1'b0;
          reg_clr[R_EX_MEM] = 1'b1;
        end
        C_LU: begin
          pc_en_o          = 1'b0;
          reg_en[R_IF_ID]  = 1'b0;
          reg_clr[R_ID_EX] = 1'b1;
        end
        C_FETCH: begin
          pc_en_o          = 1'b0;
          reg_clr[R_IF_ID] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign if_id_en_o     = reg_en[R_IF_ID];
  assign if_id_clear_o  = reg_clr[R_IF_ID];
  assign id_ex_en_o     = reg_en[R_ID_EX];
  assign id_ex_clear_o  = reg_clr[R_ID_EX];
  assign ex_mem_en_o    = reg_en[R_EX_MEM];
  assign ex_mem_clear_o = reg_clr[R_EX_MEM];
  assign mem_wb_en_o    = reg_en[R_MEM_WB];
  assign mem_wb_clear_o = reg_clr[R_MEM_WB];
  assign state_o        = state;

  // A redirect while EX is busy with a multicycle op means the datapath lost track.
  a_no_redir_in_mc: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(ex_redirect_i && mc_stall));

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter #(.W(CNT_W)) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_inc (rst_n & ~pc_en_o),
    .flush_inc (rst_n & ((cause == C_REDIR) | trap_take_o)),
    .stall_cnt (perf_stall_o),
    .flush_cnt (perf_flush_o)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       if_ready_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       id_use_rs1_i, id_use_rs2_i;
  logic       ex_valid_i, ex_is_load_i, ex_mc_start_i, ex_mc_done_i;
  logic       mem_req_i, mem_ready_i, ex_redirect_i, trap_i;
  logic       pc_en_o, if_id_en_o, if_id_clear_o, id_ex_en_o, id_ex_clear_o;
  logic       ex_mem_en_o, ex_mem_clear_o, mem_wb_en_o, mem_wb_clear_o, trap_take_o;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_o, perf_flush_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_ready_i     (if_ready_i),
    .id_rs1_i       (id_rs1_i),
    .id_use_rs1_i   (id_use_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_use_rs2_i   (id_use_rs2_i),
    .ex_valid_i     (ex_valid_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_rd_i        (ex_rd_i),
    .ex_mc_start_i  (ex_mc_start_i),
    .ex_mc_done_i   (ex_mc_done_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .ex_redirect_i  (ex_redirect_i),
    .trap_i         (trap_i),
    .pc_en_o        (pc_en_o),
    .if_id_en_o     (if_id_en_o),
    .if_id_clear_o  (if_id_clear_o),
    .id_ex_en_o     (id_ex_en_o),
    .id_ex_clear_o  (id_ex_clear_o),
    .ex_mem_en_o    (ex_mem_en_o),
    .ex_mem_clear_o (ex_mem_clear_o),
    .mem_wb_en_o    (mem_wb_en_o),
    .mem_wb_clear_o (mem_wb_clear_o),
    .trap_take_o    (trap_take_o),
    .state_o        (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,.perf_stall_o  (perf_stall_o),
    .perf_flush_o   (perf_flush_o)
`endif
  );

  // Expected vector: {pc, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr,
  //                   memwb_en, memwb_clr, trap_take, state[1:0]}
  function automatic logic [11:0] mk(input logic pc, ie, ic, de, dc, xe, xc, we, wc, tt,
                                     input logic [1:0] st);
    return {pc, ie, ic, de, dc, xe, xc, we, wc, tt, st};
  endfunction

  function automatic logic [11:0] run_v(input logic [1:0] st);
    return mk(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, st);
  endfunction

  function automatic logic [11:0] rst_v(input logic [1:0] st);
    return mk(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, st);
  endfunction

  task automatic chk(input string tag, input logic [31:0] exp);
    logic [31:0] obs;
    obs = 32'({pc_en_o, if_id_en_o, if_id_clear_o, id_ex_en_o, id_ex_clear_o,
               ex_mem_en_o, ex_mem_clear_o, mem_wb_en_o, mem_wb_clear_o,
               trap_take_o, state_o});
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%03h expected=%03h", tag, obs, exp);
      end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask
`endif

  task automatic idle();
    if_ready_i = 1; id_rs1_i = 0; id_rs2_i = 0; id_use_rs1_i = 0; id_use_rs2_i = 0;
    ex_valid_i = 0; ex_is_load_i = 0; ex_rd_i = 0; ex_mc_start_i = 0; ex_mc_done_i = 0;
    mem_req_i = 0; mem_ready_i = 0; ex_redirect_i = 0; trap_i = 0;
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #1;
    tick();
    settle(); chk("reset_state", rst_v(0));
    rst_n = 1;
    settle(); chk("idle_run", run_v(0));
    tick();

    // load x5 in EX, ID reads rs2=x5: one bubble
    ex_valid_i = 1; ex_is_load_i = 1; ex_rd_i = 5;
    id_use_rs1_i = 1; id_rs1_i = 3; id_use_rs2_i = 1; id_rs2_i = 5;
    settle(); chk("load_use_rs2", mk(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
    tick();
    ex_valid_i = 0; ex_is_load_i = 0;
    settle(); chk("load_use_release", run_v(0));
    tick();

    // rs1 matches but is not used: no stall; then used: stall
    ex_valid_i = 1; ex_is_load_i = 1; ex_rd_i = 7;
    id_rs1_i = 7; id_use_rs1_i = 0; id_rs2_i = 1; id_use_rs2_i = 1;
    settle(); chk("rs1_unused", run_v(0));
    id_use_rs1_i = 1;
    settle(); chk("load_use_rs1", mk(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
    tick();

    // load to x0 never stalls
    ex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    settle(); chk("load_x0", run_v(0));
    tick();
    idle();

    // fetch miss
    if_ready_i = 0;
    settle(); chk("fetch_miss", mk(0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0));
    tick();
    idle();

    // single-cycle multicycle op: no stall, stays RUN
    ex_mc_start_i = 1; ex_mc_done_i = 1;
    settle(); chk("mc_1cycle", run_v(0));
    tick();
    idle();
    settle(); chk("mc_1cycle_state", run_v(0));

    // multicycle op: start, 3 waits, done 4 cycles after start
    ex_mc_start_i = 1;
    settle(); chk("mc_start", mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tick();
    ex_mc_start_i = 0;
    for (int i = 0; i < 3; i++) begin
      settle(); chk($sformatf("mc_wait%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
      tick();
    end
    ex_mc_done_i = 1;
    settle(); chk("mc_done", run_v(1));
    tick();
    ex_mc_done_i = 0;
    settle(); chk("mc_back_run", run_v(0));
    tick();

    // redirect beats load-use and fetch miss
    ex_redirect_i = 1; ex_valid_i = 1; ex_is_load_i = 1; ex_rd_i = 9;
    id_use_rs1_i = 1; id_rs1_i = 9; if_ready_i = 0;
    settle(); chk("redirect_over_lu", mk(1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0));
    tick();
    idle();

    // mem stall beats redirect
    mem_req_i = 1; mem_ready_i = 0; ex_redirect_i = 1;
    settle(); chk("memstall_over_redir", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    idle();

    // trap without mem stall: immediate flush, stays RUN
    trap_i = 1;
    settle(); chk("trap_direct", mk(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0));
    tick();
    idle();
    settle(); chk("trap_direct_after", run_v(0));

    // one-cycle trap inside a 3-cycle mem stall, taken on the ack cycle
    mem_req_i = 1; mem_ready_i = 0; trap_i = 1;
    settle(); chk("trap_in_stall", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    trap_i = 0;
    settle(); chk("trap_pend1", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    tick();
    settle(); chk("trap_pend2", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    tick();
    mem_ready_i = 1;
    settle(); chk("trap_take", mk(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2));
    tick();
    idle();
    settle(); chk("trap_done", run_v(0));
    tick();

    // reset while in MC_WAIT
    ex_mc_start_i = 1;
    tick();
    ex_mc_start_i = 0;
    settle(); chk("pre_reset_mcwait", mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    rst_n = 0;
    settle(); chk("reset_comb", rst_v(1));
    tick();
    settle(); chk("reset_mid_stall", rst_v(0));
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("perf_stall_rst", perf_stall_o, 0);
    chk_cnt("perf_flush_rst", perf_flush_o, 0);
`endif
    rst_n = 1;
    settle(); chk("post_reset_run", run_v(0));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
